// File: rtl/sub32_serial_pkg.sv
// Shared types, default sizes and sizing helpers for the digit-serial subtractor.
// The optional signed-overflow output is enabled with the macro SUB32_SERIAL_OVF_EN.
package sub32_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 8;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-slice build still needs a one-bit counter.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/sub32_serial_if.sv
// Operand/result handshake bundle for sub32_serial; ovf exists only when
// SUB32_SERIAL_OVF_EN is defined.
interface sub32_serial_if
  import sub32_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB32_SERIAL_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, in1, in2, bin, out_ready,
`ifdef SUB32_SERIAL_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, bout
  );

  modport master (
    output in_valid, in1, in2, bin, out_ready,
`ifdef SUB32_SERIAL_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/sub32_serial_digit.sv
// One DIGIT-wide subtract slice: {o_bout, o_d} = i_a - i_b - i_bin.
module sub32_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_bin,
  output logic [DIGIT-1:0] o_d,
  output logic             o_bout
);

  logic [DIGIT:0] w_res;

  // The extra top bit goes to 1 exactly when the slice has to borrow.
  assign w_res  = {1'b0, i_a} - {1'b0, i_b} - {{DIGIT{1'b0}}, i_bin};
  assign o_d    = w_res[DIGIT-1:0];
  assign o_bout = w_res[DIGIT];

endmodule

// File: rtl/sub32_serial.sv
// Digit-serial WIDTH-bit subtractor with borrow-in/out, LSB slice first.
// Define SUB32_SERIAL_OVF_EN to add the registered signed-overflow flag ovf.
module sub32_serial
  import sub32_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic           clk,
  input  logic           rst_n,
  sub32_serial_if.slave  bus
);

  localparam int              NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int              CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_diff;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_borrow;
  logic               r_bout;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_last;
  logic [DIGIT-1:0]   w_a_dig;
  logic [DIGIT-1:0]   w_b_dig;
  logic [DIGIT-1:0]   w_d;
  logic               w_bout;

  assign w_a_dig  = r_a[int'(r_cnt) * DIGIT +: DIGIT];
  assign w_b_dig  = r_b[int'(r_cnt) * DIGIT +: DIGIT];
  assign w_last   = (r_cnt == LAST);
  assign w_accept = bus.in_valid && w_in_ready;

  sub32_digit #(.DIGIT(DIGIT)) u_digit (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = BUSY;
      end
      BUSY: if (w_last) w_next = DONE;
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a      <= bus.in1;
        r_b      <= bus.in2;
        r_borrow <= bus.bin;
        r_cnt    <= '0;
      end else if (r_state == BUSY) begin
        r_diff[int'(r_cnt) * DIGIT +: DIGIT] <= w_d;
        r_borrow <= w_bout;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) r_bout <= w_bout;
      end
    end
  end

`ifdef SUB32_SERIAL_OVF_EN
  logic r_ovf;
  logic w_msb_borrow_in;

  // The MSB difference bit is a ^ b ^ borrow-in, so the borrow into it is recoverable.
  assign w_msb_borrow_in = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_d[DIGIT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_ovf <= 1'b0;
    else if (r_state == BUSY && w_last)   r_ovf <= w_msb_borrow_in ^ w_bout;
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;

endmodule
